// File: rtl/wb_rsp_encoder.sv
// Response-channel encoder: buffers 34-bit Wishbone response words in a small FIFO
// and serialises each one into an ASCII packet, one byte at a time, toward a UART TX.
module wb_rsp_encoder #(
    parameter int LGFIFO = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rsp_stb,
    input  logic [33:0] i_rsp_word,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_busy,
    output logic        o_overflow,
    output logic        o_idle
);

    localparam int DEPTH = 1 << LGFIFO;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

    state_t        state_reg, state_next;
    logic [LGFIFO:0] wr_ptr_reg, wr_ptr_next;
    logic [LGFIFO:0] rd_ptr_reg, rd_ptr_next;
    logic [33:0]   mem [DEPTH];
    logic [33:0]   rd_word;
    logic [33:0]   shift_reg, shift_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          tx_stb_reg, tx_stb_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic          overflow_reg, overflow_next;
    logic          idle_reg, idle_next;
    logic          empty, full, accept, pop, push, last_nibble, is_special;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] head_char(input logic [1:0] sub);
        case (sub)
            2'b00:   return 8'h52;  // 'R'
            2'b01:   return 8'h4B;  // 'K'
            2'b10:   return 8'h41;  // 'A'
            default: return 8'h53;  // 'S'
        endcase
    endfunction

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[LGFIFO] != rd_ptr_reg[LGFIFO]) &&
                         (wr_ptr_reg[LGFIFO-1:0] == rd_ptr_reg[LGFIFO-1:0]);
    assign accept      = tx_stb_reg && !i_tx_busy;
    assign last_nibble = (cnt_reg == 4'd1);
    assign is_special  = (shift_reg[33:32] == 2'b11);
    assign rd_word     = mem[rd_ptr_reg[LGFIFO-1:0]];

    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign push          = i_rsp_stb && (!full || pop);
    assign wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    assign rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    assign overflow_next = overflow_reg || (i_rsp_stb && !push);
    assign idle_next     = (wr_ptr_next == rd_ptr_next) && (state_next == IDLE) && !tx_stb_next;

    always_ff @(posedge i_clk) begin
        if (i_reset && push) begin
            mem[wr_ptr_reg[LGFIFO-1:0]] <= i_rsp_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            tx_stb_reg   <= 1'b0;
            tx_data_reg  <= 8'h00;
            overflow_reg <= 1'b0;
            idle_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            shift_reg    <= shift_next;
            cnt_reg      <= cnt_next;
            tx_stb_reg   <= tx_stb_next;
            tx_data_reg  <= tx_data_next;
            overflow_reg <= overflow_next;
            idle_reg     <= idle_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = HEAD;
                end
            end
            HEAD: begin
                if (accept) begin
                    state_next = (shift_reg[33:32] == 2'b01) ? TAIL : BODY;
                end
            end
            BODY: begin
                if (accept && last_nibble) begin
                    state_next = TAIL;
                end
            end
            TAIL: begin
                if (accept) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = HEAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        tx_stb_next  = tx_stb_reg;
        tx_data_next = tx_data_reg;
        if (pop) begin
            shift_next   = rd_word;
            tx_stb_next  = 1'b1;
            tx_data_next = head_char(rd_word[33:32]);
        end else begin
            case (state_reg)
                HEAD: begin
                    if (accept) begin
                        if (shift_reg[33:32] == 2'b01) begin
                            tx_data_next = 8'h0A;
                        end else if (is_special) begin
                            cnt_next     = 4'd1;
                            tx_data_next = hex_char({1'b0, shift_reg[31:29]});
                        end else begin
                            cnt_next     = 4'd8;
                            tx_data_next = hex_char(shift_reg[31:28]);
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        cnt_next = cnt_reg - 4'd1;
                        if (last_nibble) begin
                            tx_data_next = 8'h0A;
                        end else begin
                            shift_next[31:0] = {shift_reg[27:0], 4'h0};
                            tx_data_next     = hex_char(shift_reg[27:24]);
                        end
                    end
                end
                TAIL: begin
                    if (accept) begin
                        tx_stb_next = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tx_stb   = tx_stb_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_overflow = overflow_reg;
    assign o_idle     = idle_reg;

endmodule

// File: tb/tb_wb_rsp_encoder.sv
// Bench for wb_rsp_encoder: a transaction-level model (word queue + byte queue of the
// packet in flight) is checked against the DUT every cycle, plus literal byte streams.
module tb_wb_rsp_encoder;

    localparam int LGFIFO = 2;
    localparam int DEPTH  = 1 << LGFIFO;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_rsp_stb = 1'b0;
    logic [33:0] i_rsp_word = '0;
    logic        i_tx_busy = 1'b0;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        o_overflow;
    logic        o_idle;

    int checks = 0;
    int failures = 0;

    wb_rsp_encoder #(.LGFIFO(LGFIFO)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_rsp_stb  (i_rsp_stb),
        .i_rsp_word (i_rsp_word),
        .o_tx_stb   (o_tx_stb),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .o_overflow (o_overflow),
        .o_idle     (o_idle)
    );

    always #5 clk = ~clk;

    // Model state: words waiting, bytes left of the packet being sent, sticky drop flag.
    logic [33:0] fifo_q[$];
    logic [7:0]  cur[$];
    bit          m_ovf = 1'b0;
    bit          started = 1'b0;
    int          cyc = 0;

    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          first_acc_cyc = -1;
    int          last_acc_cyc = -1;
    int          send_cyc = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, actual, required, $time);
        end
    endtask

    task automatic load(input logic [33:0] w);
        string hs;
        logic [31:0] p;
        hs = "0123456789ABCDEF";
        p  = w[31:0];
        case (w[33:32])
            2'b00, 2'b10: begin
                cur.push_back((w[33:32] == 2'b00) ? 8'h52 : 8'h41);
                for (int i = 7; i >= 0; i--) cur.push_back(8'(hs[int'((p >> (4 * i)) & 32'hF)]));
            end
            2'b01: cur.push_back(8'h4B);
            default: begin
                cur.push_back(8'h53);
                cur.push_back(8'(hs[int'(p[31:29])]));
            end
        endcase
        cur.push_back(8'h0A);
    endtask

    always @(posedge clk) begin
        bit acc, pop, push;
        cyc++;
        if (!i_reset) begin
            cur.delete();
            fifo_q.delete();
            m_ovf   = 1'b0;
            started = 1'b1;
        end else if (started) begin
            acc  = (cur.size() > 0) && !i_tx_busy;
            pop  = (fifo_q.size() > 0) && ((cur.size() == 0) || (acc && cur.size() == 1));
            push = i_rsp_stb && ((fifo_q.size() < DEPTH) || pop);
            if (i_rsp_stb && !push) m_ovf = 1'b1;
            if (acc) void'(cur.pop_front());
            if (pop) load(fifo_q.pop_front());
            if (push) fifo_q.push_back(i_rsp_word);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("tx_stb", 64'(o_tx_stb), 64'(cur.size() > 0));
            if (cur.size() > 0) check("tx_data", 64'(o_tx_data), 64'(cur[0]));
            check("overflow", 64'(o_overflow), 64'(m_ovf));
            check("idle", 64'(o_idle), 64'(fifo_q.size() == 0 && cur.size() == 0));
            if (i_reset && o_tx_stb && !i_tx_busy) begin
                if (got.size() == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                got.push_back(o_tx_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got.delete();
        first_acc_cyc = -1;
        last_acc_cyc  = -1;
    endtask

    task automatic send(input logic [33:0] w, input bit verbose);
        if (verbose) $display("send sub=%0d payload=%h cyc=%0d", w[33:32], w[31:0], cyc);
        send_cyc   = cyc;
        i_rsp_stb  = 1'b1;
        i_rsp_word = w;
        tick();
        i_rsp_stb  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input bit rbusy);
        int n;
        n = 0;
        while (!(o_idle && fifo_q.size() == 0 && cur.size() == 0) && n < maxc) begin
            if (rbusy) i_tx_busy = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        i_tx_busy = 1'b0;
        if (n >= maxc) check("idle_timeout", 64'(n), 64'(0));
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(name, 64'(got[i]), 64'(exp_q[i]));
        $display("stream %s bytes=%0d", name, got.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cycles=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit saw_lf;
        logic [31:0] sub;

        // Reset with response strobes pulsed; nothing may be buffered.
        i_reset = 1'b0;
        tick();
        i_rsp_stb  = 1'b1;
        i_rsp_word = {2'b01, 32'h0};
        tick();
        tick();
        i_rsp_stb = 1'b0;
        check("rst_tx_data", 64'(o_tx_data), 64'h00);
        check("rst_tx_stb", 64'(o_tx_stb), 64'(0));
        check("rst_idle", 64'(o_idle), 64'(1));
        tick();
        i_reset = 1'b1;
        clear_got();
        repeat (6) tick();
        check("post_rst_bytes", 64'(got.size()), 64'(0));
        check("post_rst_stb", 64'(o_tx_stb), 64'(0));
        check("post_rst_idle", 64'(o_idle), 64'(1));
        check("post_rst_ovf", 64'(o_overflow), 64'(0));

        // Single DATA word, no stalls.
        clear_got();
        send({2'b00, 32'hDEADBEEF}, 1'b1);
        wait_idle(100, 1'b0);
        exp_q = '{8'h52, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
        check_stream("data");
        check("data_latency", 64'(first_acc_cyc - send_cyc), 64'(2));
        check("data_span", 64'(last_acc_cyc - first_acc_cyc + 1), 64'(10));

        // ACK, SPECIAL, ADDR back to back.
        clear_got();
        send({2'b01, 32'h0}, 1'b1);
        send({2'b11, 32'h2000_0000}, 1'b1);
        send({2'b10, 32'h0000_0010}, 1'b1);
        wait_idle(100, 1'b0);
        exp_q = '{8'h4B, 8'h0A, 8'h53, 8'h31, 8'h0A, 8'h41, 8'h30, 8'h30, 8'h30,
                  8'h30, 8'h30, 8'h30, 8'h31, 8'h30, 8'h0A};
        check_stream("burst");
        check("burst_span", 64'(last_acc_cyc - first_acc_cyc + 1), 64'(15));

        // Random backpressure on a DATA packet.
        clear_got();
        send({2'b00, 32'h0123_4567}, 1'b1);
        wait_idle(400, 1'b1);
        exp_q = '{8'h52, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0A};
        check_stream("stall");

        // Overflow: six ACKs into a stalled encoder.
        clear_got();
        i_tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) send({2'b01, 32'h0}, 1'b1);
        tick();
        check("ovf_set", 64'(o_overflow), 64'(1));
        i_tx_busy = 1'b0;
        wait_idle(200, 1'b0);
        exp_q = '{8'h4B, 8'h0A, 8'h4B, 8'h0A, 8'h4B, 8'h0A, 8'h4B, 8'h0A, 8'h4B, 8'h0A};
        check_stream("ovf");
        check("ovf_sticky", 64'(o_overflow), 64'(1));

        // Reset in the middle of a DATA packet.
        clear_got();
        send({2'b00, 32'hCAFE_F00D}, 1'b1);
        n = 0;
        while (got.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("midrst_timeout", 64'(n), 64'(0));
        i_reset = 1'b0;
        tick();
        check("midrst_stb", 64'(o_tx_stb), 64'(0));
        check("midrst_ovf", 64'(o_overflow), 64'(0));
        check("midrst_bytes", 64'(got.size()), 64'(3));
        saw_lf = 1'b0;
        foreach (got[i]) if (got[i] == 8'h0A) saw_lf = 1'b1;
        check("midrst_no_tail", 64'(saw_lf), 64'(0));
        tick();
        i_reset = 1'b1;
        clear_got();
        send({2'b01, 32'h0}, 1'b1);
        wait_idle(100, 1'b0);
        exp_q = '{8'h4B, 8'h0A};
        check_stream("after_rst");

        // Randomized traffic, stalls and occasional resets, checked by the model.
        for (int i = 0; i < 2500; i++) begin
            i_reset    = ($urandom_range(0, 299) != 0);
            i_rsp_stb  = ($urandom_range(0, 99) < 30);
            sub        = $urandom_range(0, 3);
            i_rsp_word = {sub[1:0], 32'($urandom)};
            i_tx_busy  = ($urandom_range(0, 99) < 35);
            tick();
        end
        i_reset   = 1'b1;
        i_rsp_stb = 1'b0;
        wait_idle(500, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
